// File: rtl/sys_defs.sv
// Shared definitions for the ordered branch queue: depth, tag and checkpoint types,
// and the modulo-DEPTH pointer increment.
`ifndef BH_SIZE
`define BH_SIZE 8
`endif

package sys_defs;

  localparam int OBQ_DEPTH = 16;
  localparam int OBQ_TAG_W = $clog2(OBQ_DEPTH);

  typedef logic [OBQ_TAG_W-1:0] obq_tag_t;

  typedef struct packed {
    logic [`BH_SIZE-1:0] gh;
    logic [31:0]         pc;
  } obq_entry_t;

  // DEPTH is a power of two, so natural overflow is the wrap.
  function automatic obq_tag_t wrap_inc(input obq_tag_t p);
    return p + obq_tag_t'(1);
  endfunction

endpackage

// File: rtl/obq.sv
// Ordered branch queue: one {history, pc} checkpoint per in-flight branch, freed at
// retirement, truncated at a mispredicted branch whose checkpoint is replayed to gshare.
module obq
  import sys_defs::*;
#(
  parameter int DEPTH = OBQ_DEPTH,
  parameter int BH_W  = `BH_SIZE,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_en,
  input  logic [BH_W-1:0]  push_gh,
  input  logic [31:0]      push_pc,
  output logic [TAG_W-1:0] push_tag,
  input  logic             retire_en,
  input  logic             mispredict_en,
  input  logic [TAG_W-1:0] mispredict_tag,
  output logic             full,
  output logic             empty,
  output logic [TAG_W:0]   count,
  output logic             bh_pred_valid,
  output logic [BH_W-1:0]  bh_pred_gh,
  output logic [31:0]      bh_pred_pc
);

  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

  obq_entry_t       entry_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;
  logic             bh_valid_q, bh_valid_d;
  logic [BH_W-1:0]  bh_gh_q, bh_gh_d;
  logic [31:0]      bh_pc_q, bh_pc_d;

  logic             retire_ok, push_ok, mis_ok, mem_we;
  logic [TAG_W-1:0] mis_off, slot_off;
  logic [TAG_W:0]   flush_len;
  logic [DEPTH-1:0] flush_mask;
  obq_entry_t       mem_wdata;

  assign full          = (count_q == FULL_CNT);
  assign empty         = (count_q == '0);
  assign count         = count_q;
  assign push_tag      = tail_q;
  assign bh_pred_valid = bh_valid_q;
  assign bh_pred_gh    = bh_gh_q;
  assign bh_pred_pc    = bh_pc_q;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    valid_d    = valid_q;
    bh_valid_d = 1'b0;
    bh_gh_d    = bh_gh_q;
    bh_pc_d    = bh_pc_q;
    mem_we     = 1'b0;
    mem_wdata  = '{gh: push_gh, pc: push_pc};
    slot_off   = '0;

    retire_ok = retire_en && !empty;
    mis_ok    = mispredict_en && valid_q[mispredict_tag];
    // A retire frees the head in the same cycle, so a full queue still accepts the push.
    push_ok   = push_en && !mis_ok && (!full || retire_ok);

    // Flush runs from the tag to tail-1; its length is derived from count so that a
    // full queue flushed at its head (tag == tail) clears every entry.
    mis_off   = mispredict_tag - head_q;
    flush_len = count_q - {1'b0, mis_off};
    for (int i = 0; i < DEPTH; i++) begin
      slot_off      = TAG_W'(i) - mispredict_tag;
      flush_mask[i] = ({1'b0, slot_off} < flush_len);
    end

    if (mis_ok) begin
      valid_d    = valid_q & ~flush_mask;
      tail_d     = mispredict_tag;
      count_d    = {1'b0, mis_off};
      bh_valid_d = 1'b1;
      bh_gh_d    = entry_q[mispredict_tag].gh;
      bh_pc_d    = entry_q[mispredict_tag].pc;
      if (retire_ok) begin
        valid_d[head_q] = 1'b0;
        head_d          = wrap_inc(head_q);
        if (mispredict_tag == head_q) begin
          tail_d  = wrap_inc(head_q);
          count_d = '0;
        end else begin
          count_d = {1'b0, mis_off - 1'b1};
        end
      end
    end else begin
      if (retire_ok) begin
        valid_d[head_q] = 1'b0;
        head_d          = wrap_inc(head_q);
      end
      if (push_ok) begin
        valid_d[tail_q] = 1'b1;
        tail_d          = wrap_inc(tail_q);
        mem_we          = 1'b1;
      end
      count_d = count_q + {{TAG_W{1'b0}}, push_ok} - {{TAG_W{1'b0}}, retire_ok};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      bh_valid_q <= 1'b0;
      bh_gh_q    <= '0;
      bh_pc_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      valid_q    <= valid_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      bh_valid_q <= bh_valid_d;
      bh_gh_q    <= bh_gh_d;
      bh_pc_q    <= bh_pc_d;
    end
  end

  // NOTE: checkpoint storage is not reset; the valid bits gate every read of it.
  always_ff @(posedge clock) begin
    if (mem_we) entry_q[tail_q] <= mem_wdata;
  end

endmodule
